rv32i_alu_decode_stage: RTL and testbench

Pipelined RV32I decode stage that turns 32-bit OP and OP-IMM instruction words into the 10-bit `alu_op` code and operand selects consumed by the `ALU` block. It sits between instruction fetch and execute, with a valid/ready handshake on both sides and one registered pipeline stage. It also supports a synchronous flush and an illegal-instruction counter.

---
 rtl/rv32i_pkg.sv | 47 ++++
 rtl/rv32i_alu_decoder.sv | 65 ++++++
 rtl/rv32i_alu_decode_stage.sv | 111 +++++++++++
 tb/tb_rv32i_alu_decode_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I OP/OP-IMM ALU decode slice.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [9:0] {
    ALU_NONE = 10'd0,
    ALU_ADD  = 10'd1,
    ALU_SUB  = 10'd2,
    ALU_SLL  = 10'd3,
    ALU_SLT  = 10'd5,
    ALU_SLTU = 10'd6,
    ALU_XOR  = 10'd7,
    ALU_SRL  = 10'd8,
    ALU_SRA  = 10'd9,
    ALU_OR   = 10'd10,
    ALU_AND  = 10'd11
  } alu_op_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  // Base funct3 mapping shared by OP and OP-IMM (funct7 = F7_BASE flavour).
  function automatic alu_op_t f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational decode of one RV32I OP/OP-IMM word into a dec_t record.
module rv32i_alu_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          dec.alu_op  = f3_to_op(f3);
          dec.illegal = 1'b0;
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.alu_op  = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
          dec.illegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        // Shifts carry a 5-bit shamt; the upper 7 bits act as a funct7.
        case (f3)
          3'b001: begin
            if (f7 == F7_BASE) begin
              dec.alu_op  = ALU_SLL;
              dec.imm     = {27'b0, instr[24:20]};
              dec.illegal = 1'b0;
            end
          end
          3'b101: begin
            if (f7 == F7_BASE || f7 == F7_ALT) begin
              dec.alu_op  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
              dec.imm     = {27'b0, instr[24:20]};
              dec.illegal = 1'b0;
            end
          end
          default: begin
            dec.alu_op  = f3_to_op(f3);
            dec.imm     = {{20{instr[31]}}, instr[31:20]};
            dec.illegal = 1'b0;
          end
        endcase
        if (!dec.illegal) begin
          dec.rs2     = 5'd0;
          dec.use_imm = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_alu_decode_stage.sv
// Registered RV32I ALU decode stage with flush and saturating illegal counter.
// Optional second (skid) entry and registered in_ready when DECODE_SKID_EN is defined.
module rv32i_alu_decode_stage
  import rv32i_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        out_alu_op,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_use_imm,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  // Handshake: a beat moves on a rising edge where valid && ready; once valid
  // is high the producer holds its data until that edge (or a flush/reset).
  dec_t             dec_in;
  dec_t             main_q;
  logic             main_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             out_xfer;

  rv32i_alu_decoder u_decoder (
    .instr (in_instr),
    .dec   (dec_in)
  );

  assign accept   = in_valid && in_ready;
  assign out_xfer = main_valid_q && out_ready;

`ifdef DECODE_SKID_EN
  dec_t skid_q;
  logic skid_valid_q;

  assign in_ready = !skid_valid_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      if (rst) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else if (!main_valid_q || out_ready) begin
      // Main slot frees up: older skid entry goes first to keep order.
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        main_q       <= dec_in;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec_in;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
    end else if (accept) begin
      main_q       <= dec_in;
      main_valid_q <= 1'b1;
    end else if (out_ready) begin
      main_valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_xfer && main_q.illegal && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_alu_op  = main_q.alu_op;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_use_imm = main_q.use_imm;
  assign out_illegal = main_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv32i_alu_decode_stage.sv
// Directed bench for rv32i_alu_decode_stage (default or DECODE_SKID_EN build).
module tb_rv32i_alu_decode_stage;

  localparam int CNT_W = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_imm;
  logic [9:0]  out_alu_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_use_imm, out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  rv32i_alu_decode_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_op  (out_alu_op),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_use_imm (out_use_imm),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [31:0] instr, input logic [9:0] op,
                          input logic [31:0] imm, input logic use_imm, input logic ill);
    in_valid = 1'b1;
    in_instr = instr;
    cycle();
    chk({tag, ".valid"},   32'(out_valid),   32'd1);
    chk({tag, ".op"},      32'(out_alu_op),  32'(op));
    chk({tag, ".imm"},     out_imm,          imm);
    chk({tag, ".use_imm"}, 32'(out_use_imm), 32'(use_imm));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic idle_cnt_chk(input string tag, input int exp_cnt);
    in_valid = 1'b0;
    cycle();
    chk({tag, ".valid"}, 32'(out_valid),   32'd0);
    chk({tag, ".cnt"},   32'(illegal_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [31:0] stall_tbl[3];
    int idx;
    int received;
    int exp_accept;
    bit in_fire, out_fire;
    logic [4:0] got_rd;

    stall_tbl[0] = 32'h00100093; // addi x1,x0,1
    stall_tbl[1] = 32'h00200113; // addi x2,x0,2
    stall_tbl[2] = 32'h00300193; // addi x3,x0,3
`ifdef DECODE_SKID_EN
    exp_accept = 2;
`else
    exp_accept = 1;
`endif

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    chk("reset.valid",    32'(out_valid),   32'd0);
    chk("reset.op",       32'(out_alu_op),  32'd0);
    chk("reset.imm",      out_imm,          32'd0);
    chk("reset.cnt",      32'(illegal_cnt), 32'd0);
    chk("reset.in_ready", 32'(in_ready),    32'd1);

    out_ready = 1'b1;
    step_chk("add", 32'h002081B3, 10'd1, 32'h0, 1'b0, 1'b0);
    chk("add.rs1", 32'(out_rs1), 32'd1);
    chk("add.rs2", 32'(out_rs2), 32'd2);
    chk("add.rd",  32'(out_rd),  32'd3);
    step_chk("addi", 32'hFFF00293, 10'd1, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("addi.rs2", 32'(out_rs2), 32'd0);
    chk("addi.rd",  32'(out_rd),  32'd5);
    step_chk("srai", 32'h4042D313, 10'd9, 32'h4, 1'b1, 1'b0);
    chk("srai.rs1", 32'(out_rs1), 32'd5);
    chk("srai.rd",  32'(out_rd),  32'd6);

    step_chk("ill_xor_alt", 32'h4020C1B3, 10'd0, 32'h0, 1'b0, 1'b1);
    chk("ill_xor_alt.cnt", 32'(illegal_cnt), 32'd0);
    step_chk("ill_zero", 32'h00000000, 10'd0, 32'h0, 1'b0, 1'b1);
    chk("ill_zero.cnt", 32'(illegal_cnt), 32'd1);
    idle_cnt_chk("ill_pair", 2);

    step_chk("sub",      32'h402081B3, 10'd2,  32'h0,        1'b0, 1'b0);
    step_chk("or",       32'h0020E1B3, 10'd10, 32'h0,        1'b0, 1'b0);
    step_chk("slli",     32'h00311093, 10'd3,  32'h3,        1'b1, 1'b0);
    step_chk("slli_bad", 32'h40311093, 10'd0,  32'h0,        1'b0, 1'b1);
    step_chk("andi",     32'h80017093, 10'd11, 32'hFFFFF800, 1'b1, 1'b0);
    step_chk("sltiu",    32'h7FF13093, 10'd6,  32'h000007FF, 1'b1, 1'b0);
    idle_cnt_chk("table", 3);

    // Stall with three pending instructions, then drain in order.
    out_ready = 1'b0;
    idx = 0;
    received = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3);
      in_instr = stall_tbl[idx < 3 ? idx : 2];
      @(negedge clk);
      in_fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (in_fire) begin
        exp_q.push_back(stall_tbl[idx][11:7]);
        idx++;
      end
    end
    chk("stall.accepted", 32'(idx),      32'(exp_accept));
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    chk("stall.hold_rd",  32'(out_rd),   32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx == 3 && exp_q.size() == 0) break;
      in_valid = (idx < 3);
      in_instr = stall_tbl[idx < 3 ? idx : 2];
      @(negedge clk);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      got_rd   = out_rd;
      @(posedge clk);
      #1;
      if (out_fire) begin
        received++;
        if (exp_q.size() == 0) chk("drain.extra", 32'(got_rd), 32'h1F);
        else chk("drain.order", 32'(got_rd), 32'(exp_q.pop_front()));
      end
      if (in_fire) begin
        exp_q.push_back(stall_tbl[idx][11:7]);
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("drain.sent",     32'(idx),          32'd3);
    chk("drain.received", 32'(received),     32'd3);
    chk("drain.pending",  32'(exp_q.size()), 32'd0);
    cycle();
    chk("drain.empty", 32'(out_valid), 32'd0);

    // Flush with an entry held and a new input in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3;
    cycle();
    chk("flush.pre_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h402081B3; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush.valid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("flush.gone", 32'(out_valid), 32'd0);
    end
    chk("flush.cnt", 32'(illegal_cnt), 32'd3);

    step_chk("ill_a", 32'h00000000, 10'd0, 32'h0, 1'b0, 1'b1);
    step_chk("ill_b", 32'hFFFFFFFF, 10'd0, 32'h0, 1'b0, 1'b1);
    idle_cnt_chk("cnt5", 5);

    // Reset while an entry is stalled at the output.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3;
    cycle();
    chk("rst_mid.pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; in_instr = 32'h00000000;
    cycle();
    chk("rst_mid.valid",    32'(out_valid),   32'd0);
    chk("rst_mid.op",       32'(out_alu_op),  32'd0);
    chk("rst_mid.rs1",      32'(out_rs1),     32'd0);
    chk("rst_mid.rd",       32'(out_rd),      32'd0);
    chk("rst_mid.illegal",  32'(out_illegal), 32'd0);
    chk("rst_mid.cnt",      32'(illegal_cnt), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready),    32'd1);
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    chk("post_rst.valid", 32'(out_valid), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
